// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating counters and saturating stats.
// Define BP_GSHARE_EN to XOR a global branch history into the table index.
module branch_predictor #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_is_jmp,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic [WORD_SIZE-1:0] upd_fetched_pc,
  output logic                 mispredict,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [15:0]          stat_branches,
  output logic [15:0]          stat_mispredicts
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WNT = {CTR_BITS{1'b1}} >> 1;
  localparam logic [CTR_BITS-1:0] CTR_WT = ~CTR_WNT;

  if (GHR_BITS > INDEX_BITS || CTR_BITS < 1) begin : g_bad_cfg
    $error("branch_predictor: need GHR_BITS <= INDEX_BITS and CTR_BITS >= 1");
  end

  logic [ENTRIES-1:0]    valid;
  logic [ENTRIES-1:0]    jmp;
  logic [TAG_BITS-1:0]   tag    [ENTRIES];
  logic [WORD_SIZE-1:0]  target [ENTRIES];
  logic [CTR_BITS-1:0]   ctr    [ENTRIES];
  logic [INDEX_BITS-1:0] hash;
  logic [INDEX_BITS-1:0] l_idx;
  logic [INDEX_BITS-1:0] u_idx;
  logic                  u_hit;
  logic                  act_taken;

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;
  assign hash = INDEX_BITS'(ghr);
`else
  assign hash = '0;
`endif

  assign l_idx       = if_pc[INDEX_BITS-1:0] ^ hash;
  assign u_idx       = upd_pc[INDEX_BITS-1:0] ^ hash;
  assign pred_hit    = valid[l_idx] && tag[l_idx] == if_pc[WORD_SIZE-1:INDEX_BITS];
  assign pred_taken  = pred_hit && (jmp[l_idx] || ctr[l_idx][CTR_BITS-1]);
  assign pred_target = pred_taken ? target[l_idx] : if_pc + WORD_SIZE'(1);
  assign u_hit       = valid[u_idx] && tag[u_idx] == upd_pc[WORD_SIZE-1:INDEX_BITS];
  assign act_taken   = upd_is_jmp || upd_taken;
  assign redirect_pc = act_taken ? upd_target : upd_pc + WORD_SIZE'(1);
  assign mispredict  = upd_valid && redirect_pc != upd_fetched_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid            <= '0;
      jmp              <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
`ifdef BP_GSHARE_EN
      ghr              <= '0;
`endif
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_WNT;
      end
    end else if (upd_valid) begin
      stat_branches <= &stat_branches ? stat_branches : stat_branches + 16'd1;
      if (mispredict && !(&stat_mispredicts)) stat_mispredicts <= stat_mispredicts + 16'd1;
      if (act_taken) begin
        valid[u_idx]  <= 1'b1;
        jmp[u_idx]    <= upd_is_jmp;
        tag[u_idx]    <= upd_pc[WORD_SIZE-1:INDEX_BITS];
        target[u_idx] <= upd_target;
        ctr[u_idx]    <= !u_hit ? CTR_WT : &ctr[u_idx] ? ctr[u_idx] : ctr[u_idx] + 1'b1;
      end else if (u_hit && ctr[u_idx] != '0) begin
        ctr[u_idx] <= ctr[u_idx] - 1'b1;
      end
`ifdef BP_GSHARE_EN
      if (!upd_is_jmp) ghr <= (ghr << 1) | GHR_BITS'(upd_taken);
`endif
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus async-reset and statistics-saturation sequences.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] if_pc = '0;
  logic        pred_hit, pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = '0;
  logic        upd_is_jmp = 1'b0;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = '0;
  logic [15:0] upd_fetched_pc = '0;
  logic        mispredict;
  logic [15:0] redirect_pc, stat_branches, stat_mispredicts;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jmp(upd_is_jmp), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_fetched_pc(upd_fetched_pc),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic        uv;
    logic [15:0] upc;
    logic        jmp;
    logic        tk;
    logic [15:0] tgt;
    logic [15:0] fpc;
    logic [15:0] ipc;
    logic        hit;
    logic        ptk;
    logic [15:0] ptgt;
    logic        mis;
    logic [15:0] rpc;
    logic [15:0] nb;
    logic [15:0] nm;
  } vec_t;

  vec_t v [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_lookup(input string tag, input logic h, input logic t, input logic [15:0] tg);
    chk({tag, " pred_hit"}, 32'(pred_hit), 32'(h));
    chk({tag, " pred_taken"}, 32'(pred_taken), 32'(t));
    chk({tag, " pred_target"}, 32'(pred_target), 32'(tg));
  endtask

  task automatic set_upd(input logic uv, input logic [15:0] pc, input logic j, input logic t,
                         input logic [15:0] tg, input logic [15:0] f);
    upd_valid = uv; upd_pc = pc; upd_is_jmp = j; upd_taken = t; upd_target = tg; upd_fetched_pc = f;
  endtask

  initial begin
    v[0]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0, 16'h0011, 0, 16'h0001, 0, 0};
    v[1]  = '{1, 16'h0010, 0, 1, 16'h0020, 16'h0011, 16'h0010, 0, 0, 16'h0011, 1, 16'h0020, 0, 0};
    v[2]  = '{0, 16'h0010, 0, 1, 16'h0020, 16'h0011, 16'h0010, 1, 1, 16'h0020, 0, 16'h0020, 1, 1};
    v[3]  = '{1, 16'h0010, 0, 0, 16'h0020, 16'h0020, 16'h0010, 1, 1, 16'h0020, 1, 16'h0011, 1, 1};
    v[4]  = '{1, 16'h0010, 0, 0, 16'h0020, 16'h0011, 16'h0010, 1, 0, 16'h0011, 0, 16'h0011, 2, 2};
    v[5]  = '{1, 16'h0010, 0, 1, 16'h0020, 16'h0011, 16'h0010, 1, 0, 16'h0011, 1, 16'h0020, 3, 2};
    v[6]  = '{1, 16'h0010, 0, 1, 16'h0020, 16'h0011, 16'h0010, 1, 0, 16'h0011, 1, 16'h0020, 4, 3};
    v[7]  = '{1, 16'h0010, 0, 1, 16'h0020, 16'h0020, 16'h0010, 1, 1, 16'h0020, 0, 16'h0020, 5, 4};
    v[8]  = '{1, 16'h0010, 0, 1, 16'h0020, 16'h0020, 16'h0010, 1, 1, 16'h0020, 0, 16'h0020, 6, 4};
    v[9]  = '{1, 16'h0010, 0, 0, 16'h0020, 16'h0020, 16'h0010, 1, 1, 16'h0020, 1, 16'h0011, 7, 4};
    v[10] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 1, 1, 16'h0020, 0, 16'h0001, 8, 5};
    v[11] = '{1, 16'h0110, 0, 1, 16'h0040, 16'h0111, 16'h0110, 0, 0, 16'h0111, 1, 16'h0040, 8, 5};
    v[12] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0, 16'h0011, 0, 16'h0001, 9, 6};
    v[13] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0110, 1, 1, 16'h0040, 0, 16'h0001, 9, 6};
    v[14] = '{1, 16'hFFFF, 1, 0, 16'h0004, 16'h0000, 16'hFFFF, 0, 0, 16'h0000, 1, 16'h0004, 9, 6};
    v[15] = '{1, 16'hFFFF, 1, 0, 16'h0004, 16'h0004, 16'hFFFF, 1, 1, 16'h0004, 0, 16'h0004, 10, 7};
    v[16] = '{1, 16'hFFFF, 0, 0, 16'h0004, 16'h0004, 16'hFFFF, 1, 1, 16'h0004, 1, 16'h0000, 11, 7};
    v[17] = '{1, 16'hFFFF, 0, 0, 16'h0004, 16'h0004, 16'hFFFF, 1, 1, 16'h0004, 1, 16'h0000, 12, 8};
    v[18] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 1, 16'h0004, 0, 16'h0001, 13, 9};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      set_upd(v[i].uv, v[i].upc, v[i].jmp, v[i].tk, v[i].tgt, v[i].fpc);
      if_pc = v[i].ipc;
      #1;
      chk_lookup($sformatf("vec%0d", i), v[i].hit, v[i].ptk, v[i].ptgt);
      chk($sformatf("vec%0d mispredict", i), 32'(mispredict), 32'(v[i].mis));
      chk($sformatf("vec%0d redirect_pc", i), 32'(redirect_pc), 32'(v[i].rpc));
      chk($sformatf("vec%0d stat_branches", i), 32'(stat_branches), 32'(v[i].nb));
      chk($sformatf("vec%0d stat_mispredicts", i), 32'(stat_mispredicts), 32'(v[i].nm));
      @(negedge clk);
    end

    // asynchronous reset in the middle of a cycle with an update pending
    set_upd(1, 16'h0010, 0, 1, 16'h0020, 16'h0011);
    if_pc = 16'h0110;
    #2 reset_n = 1'b0;
    #1;
    chk_lookup("async_rst", 0, 0, 16'h0111);
    chk("async_rst stat_branches", 32'(stat_branches), 0);
    chk("async_rst stat_mispredicts", 32'(stat_mispredicts), 0);
    chk("async_rst mispredict", 32'(mispredict), 1);
    chk("async_rst redirect_pc", 32'(redirect_pc), 32'h0020);
    @(posedge clk); #1;
    chk_lookup("rst_held", 0, 0, 16'h0111);
    chk("rst_held stat_branches", 32'(stat_branches), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_upd(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    if_pc = 16'h0010;
    #1;
    chk_lookup("first_edge_upd", 1, 1, 16'h0020);
    chk("first_edge_upd stat_branches", 32'(stat_branches), 1);
    chk("first_edge_upd stat_mispredicts", 32'(stat_mispredicts), 1);
    if_pc = 16'hFFFF;
    #1;
    chk_lookup("jmp_cleared", 0, 0, 16'h0000);

    // statistics saturate instead of wrapping
    @(negedge clk);
    set_upd(1, 16'h0030, 0, 0, 16'h0000, 16'h0000);
    repeat (65540) @(negedge clk);
    set_upd(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("sat stat_branches", 32'(stat_branches), 32'hFFFF);
    chk("sat stat_mispredicts", 32'(stat_mispredicts), 32'hFFFF);
    if_pc = 16'h0030;
    #1;
    chk_lookup("not_taken_miss_no_alloc", 0, 0, 16'h0031);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry saturating counters for the 5-stage pipelined data path. Replaces the fixed BTB plus single shared counter. The IF stage queries it combinationally with the fetch PC. The ID stage reports each resolved branch or jump, and the block returns a mispredict/redirect decision, updates its tables and keeps performance counters.

## Interface
Parameters:
- WORD_SIZE, 16, PC/target width
- INDEX_BITS, 4, log2 of entry count (16 entries)
- CTR_BITS, 2, saturating counter width (>=1)
- GHR_BITS, 4, global history length (used only with BP_GSHARE_EN; must be <= INDEX_BITS)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  reset, asynchronous, active-low
- if_pc  in  WORD_SIZE  current fetch PC
- pred_hit  out  1  valid entry with matching tag for if_pc
- pred_taken  out  1  prediction: redirect fetch to pred_target
- pred_target  out  WORD_SIZE  predicted next PC
- upd_valid  in  1  ID stage resolved a branch/jump this cycle (already gated by stall)
- upd_pc  in  WORD_SIZE  PC of the resolved instruction
- upd_is_jmp  in  1  unconditional (JMP/JAL/JPR/JRL)
- upd_taken  in  1  actual outcome (ignored when upd_is_jmp; treated as 1)
- upd_target  in  WORD_SIZE  actual taken target
- upd_fetched_pc  in  WORD_SIZE  PC actually fetched after upd_pc
- mispredict  out  1  combinational: upd_valid && correct next PC != upd_fetched_pc
- redirect_pc  out  WORD_SIZE  correct next PC: taken ? upd_target : upd_pc+1
- stat_branches  out  16  resolved-update count
- stat_mispredicts  out  16  mispredict count

## Operation
- Entry i fields: valid, tag = pc[WORD_SIZE-1:INDEX_BITS], target, ctr[CTR_BITS-1:0], jmp.
- Index: pc[INDEX_BITS-1:0]. With BP_GSHARE_EN, the low GHR_BITS of the index are XORed with ghr.
- Lookup (combinational):
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && (jmp || ctr MSB).
  - pred_target = pred_taken ? target : if_pc+1.
- Update on posedge when upd_valid, with actual taken T = upd_is_jmp || upd_taken:
  - Hit, T=1: target<=upd_target; jmp<=upd_is_jmp; ctr saturating +1.
  - Hit, T=0: ctr saturating -1. Target is unchanged.
  - Miss, T=1: allocate (overwrite the index). valid<=1, tag, target, jmp<=upd_is_jmp, ctr<=weakly taken (MSB=1, other bits 0).
  - Miss, T=0: no change.
- Counter arithmetic: unsigned CTR_BITS. It holds at all-ones on increment and at 0 on decrement; it never wraps.
- Statistics:
  - stat_branches +1 on every upd_valid.
  - stat_mispredicts +1 when upd_valid && mispredict.
  - Both saturate at 16'hFFFF.
- PC+1 arithmetic is WORD_SIZE bits and wraps: FFFF+1 = 0000.

## Timing
- Lookup latency: 0 cycles (combinational from if_pc and table state).
- Update latency: visible to lookups from the cycle after the edge where upd_valid was sampled.
- Same-cycle lookup and update of one index: the lookup returns the pre-update contents.
- mispredict and redirect_pc are combinational in the update cycle. The data path uses them to flush IF/ID and to select nextPC in that same cycle.
- Reset (asynchronous, any time, including mid-update): all valid<=0, all ctr<=weakly not-taken (MSB=0, other bits 1), ghr<=0, stats<=0. During and immediately after reset: pred_hit=0, pred_taken=0, pred_target=if_pc+1, stats=0. mispredict follows its inputs. An update coincident with reset deassertion's first edge is applied normally.

## Configuration
- BP_GSHARE_EN defined:
  - A GHR_BITS-bit global history register shifts in upd_taken (LSB) on every upd_valid with upd_is_jmp=0.
  - Lookup and update indices both XOR the current ghr. The update uses the ghr value before that cycle's shift.
- BP_GSHARE_EN undefined: no ghr register; index = pc[INDEX_BITS-1:0]; the GHR_BITS parameter is ignored.

## Test plan
- Reset, then if_pc=0x0010 -> pred_hit=0, pred_taken=0, pred_target=0x0011, stats 0.
- Update upd_pc=0x0010, taken, target 0x0020, upd_fetched_pc=0x0011 -> mispredict=1, redirect_pc=0x0020. Next cycle if_pc=0x0010 -> hit, taken, pred_target=0x0020; stat_mispredicts=1.
- Same entry: 2 not-taken updates -> ctr 10->01->00, pred_taken=0 and pred_target=0x0011. 3 taken updates -> saturates at 11. A further taken update keeps 11.
- Aliasing: update pc 0x0010 then pc 0x0110 (same index, both taken) -> lookup 0x0010 misses, 0x0110 hits.
- Jump at 0xFFFF to 0x0004 -> entry jmp=1, always predicted taken. A not-taken-style redirect never occurs. Not-taken arithmetic check: redirect_pc for a not-taken branch at 0xFFFF = 0x0000.
- With BP_GSHARE_EN, pattern T,N,T,N at one pc -> after warm-up, 0 mispredicts over 8 further iterations. Assert reset_n low mid-sequence -> all outputs return to reset values immediately.
